// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the multicycle RV32I control unit:
// ALU select codes, opcodes, FSM states and writeback/PC mux encodings.
package alu_ctrl_pkg;

  localparam logic [5:0] ALU_NOP  = 6'b000000;
  localparam logic [5:0] ALU_ADD  = 6'b000001;
  localparam logic [5:0] ALU_SUB  = 6'b100001;
  localparam logic [5:0] ALU_SLL  = 6'b000101;
  localparam logic [5:0] ALU_SLT  = 6'b001001;
  localparam logic [5:0] ALU_SLTU = 6'b001101;
  localparam logic [5:0] ALU_XOR  = 6'b010001;
  localparam logic [5:0] ALU_SRL  = 6'b010101;
  localparam logic [5:0] ALU_SRA  = 6'b110101;
  localparam logic [5:0] ALU_OR   = 6'b011001;
  localparam logic [5:0] ALU_AND  = 6'b011101;
  localparam logic [5:0] ALU_EQ   = 6'b000010;
  localparam logic [5:0] ALU_NE   = 6'b000110;
  localparam logic [5:0] ALU_LT   = 6'b010010;
  localparam logic [5:0] ALU_GE   = 6'b010110;
  localparam logic [5:0] ALU_LTU  = 6'b011010;
  localparam logic [5:0] ALU_GEU  = 6'b011110;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] ST_START  = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_TRAP   = 3'd6;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_REL   = 2'b01;
  localparam logic [1:0] PC_JALR  = 2'b10;

  typedef enum logic [3:0] {
    C_NONE,
    C_REG,
    C_IMM,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_LUI,
    C_AUIPC,
    C_JAL,
    C_JALR
  } cls_e;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/alu_ctrl_imm_gen.sv
// Combinational immediate decoder for the latched instruction word.
// Shift-immediates yield the bare shamt since the ALU shifts by all of B.
module alu_ctrl_imm_gen
  import alu_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output logic [31:0] imm
);

  logic [6:0] opc;
  logic [2:0] f3;

  assign opc = ir[6:0];
  assign f3  = ir[14:12];

  always_comb begin
    imm = 32'd0;
    unique case (opc)
      OP_IMM: begin
        if (f3 == 3'b001 || f3 == 3'b101)
          imm = {27'd0, ir[24:20]};
        else
          imm = sext12(ir[31:20]);
      end
      OP_LOAD, OP_JALR:
        imm = sext12(ir[31:20]);
      OP_STORE:
        imm = sext12({ir[31:25], ir[11:7]});
      OP_BRANCH:
        imm = {{19{ir[31]}}, ir[31], ir[7],
               ir[30:25], ir[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {ir[31:12], 12'd0};
      OP_JAL:
        imm = {{11{ir[31]}}, ir[31], ir[19:12],
               ir[20], ir[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multicycle RV32I control FSM: fetches into IR, decodes, and
// sequences EXEC/MEM/WB while driving the ALU select bus.
module alu_ctrl_fsm
  import alu_ctrl_pkg::*;
#(
  parameter bit RESET_TRAP = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        cmp,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic [5:0]  alu_s,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic [2:0]  funct3,
  output logic [31:0] imm,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        illegal
);

  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic [31:0] ir;
  cls_e        cls;
  logic        legal;
  logic [5:0]  alu_code;
  logic        pc_we_raw;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;

  assign opc      = ir[6:0];
  assign f3       = ir[14:12];
  assign f7       = ir[31:25];
  assign rs1_addr = ir[19:15];
  assign rs2_addr = ir[24:20];
  assign rd_addr  = ir[11:7];
  assign funct3   = f3;

  alu_ctrl_imm_gen u_imm (
    .ir  (ir),
    .imm (imm)
  );

  always_comb begin
    cls   = C_NONE;
    legal = 1'b0;
    unique case (opc)
      OP_LUI:   begin cls = C_LUI;   legal = 1'b1; end
      OP_AUIPC: begin cls = C_AUIPC; legal = 1'b1; end
      OP_JAL:   begin cls = C_JAL;   legal = 1'b1; end
      OP_JALR: begin
        cls   = C_JALR;
        legal = (f3 == 3'b000);
      end
      OP_BRANCH: begin
        cls   = C_BRANCH;
        legal = (f3 != 3'b010) && (f3 != 3'b011);
      end
      OP_LOAD: begin
        cls   = C_LOAD;
        legal = (f3 != 3'b011) && (f3 != 3'b110)
             && (f3 != 3'b111);
      end
      OP_STORE: begin
        cls   = C_STORE;
        legal = (f3 == 3'b000) || (f3 == 3'b001)
             || (f3 == 3'b010);
      end
      OP_IMM: begin
        cls = C_IMM;
        if (f3 == 3'b001)
          legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101)
          legal = (f7 == 7'b0000000)
               || (f7 == 7'b0100000);
        else
          legal = 1'b1;
      end
      OP_REG: begin
        cls = C_REG;
        if (f7 == 7'b0000000)
          legal = 1'b1;
        else if (f7 == 7'b0100000)
          legal = (f3 == 3'b000) || (f3 == 3'b101);
        else
          legal = 1'b0;
      end
      default: begin cls = C_NONE; legal = 1'b0; end
    endcase
  end

  // Select code layout is {b5, funct3, is_br, is_arith}
  always_comb begin
    alu_code = ALU_ADD;
    unique case (cls)
      C_REG:    alu_code = {ir[30], f3, 2'b01};
      C_IMM:    alu_code = {(f3 == 3'b101) & ir[30],
                            f3, 2'b01};
      C_BRANCH: alu_code = {1'b0, f3, 2'b10};
      default:  alu_code = ALU_ADD;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_START:  state_nx = ST_FETCH;
      ST_FETCH:  if (mem_ready) state_nx = ST_DECODE;
      ST_DECODE: state_nx = legal ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        if (cls == C_BRANCH)
          state_nx = ST_FETCH;
        else if (cls == C_LOAD || cls == C_STORE)
          state_nx = ST_MEM;
        else
          state_nx = ST_WB;
      end
      ST_MEM: begin
        if (mem_ready)
          state_nx = (cls == C_LOAD) ? ST_WB : ST_FETCH;
      end
      ST_WB:   state_nx = ST_FETCH;
      ST_TRAP: state_nx = ST_TRAP;
      default: state_nx = ST_START;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_START;
      ir      <= 32'd0;
      illegal <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_FETCH && mem_ready)
        ir <= mem_rdata;
      if (state == ST_DECODE && !legal)
        illegal <= 1'b1;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    alu_s     = ALU_NOP;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    pc_we_raw = 1'b0;
    pc_sel    = PC_PLUS4;
    unique case (state)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      ST_EXEC: begin
        alu_s     = alu_code;
        alu_a_sel = (cls == C_AUIPC) || (cls == C_JAL);
        alu_b_sel = (cls != C_REG) && (cls != C_BRANCH);
        if (cls == C_BRANCH) begin
          pc_we_raw = 1'b1;
          pc_sel    = cmp ? PC_REL : PC_PLUS4;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls == C_STORE);
        if (cls == C_STORE)
          pc_we_raw = mem_ready;
      end
      ST_WB: begin
        reg_we    = 1'b1;
        pc_we_raw = 1'b1;
        unique case (1'b1)
          cls == C_JAL: begin
            pc_sel = PC_REL;
            wb_sel = WB_PC4;
          end
          cls == C_JALR: begin
            pc_sel = PC_JALR;
            wb_sel = WB_PC4;
          end
          cls == C_LUI:  wb_sel = WB_IMM;
          cls == C_LOAD: wb_sel = WB_MEM;
          default:       wb_sel = WB_ALU;
        endcase
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign pc_we = pc_we_raw & ~(RESET_TRAP & illegal);

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed bench for alu_ctrl_fsm: walks ADD, SRAI, BNE, LW, SW,
// reset-in-MEM and an illegal word, checking strobes each cycle.
module tb_alu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        cmp;
  logic        mem_req;
  logic        mem_we;
  logic        ir_we;
  logic [5:0]  alu_s;
  logic        alu_a_sel;
  logic        alu_b_sel;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        illegal;

  int passes = 0;
  int fails  = 0;

  alu_ctrl_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .cmp       (cmp),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .ir_we     (ir_we),
    .alu_s     (alu_s),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rd_addr   (rd_addr),
    .funct3    (funct3),
    .imm       (imm),
    .reg_we    (reg_we),
    .wb_sel    (wb_sel),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present a word in FETCH and leave the FSM in DECODE
  task automatic fetch(input logic [31:0] w);
    mem_rdata = w;
    mem_ready = 1'b1;
    #1;
    chk("fetch_ir_we", 32'(ir_we), 32'd1);
    tick();
    mem_ready = 1'b0;
  endtask

  logic [10:0] strobes;
  assign strobes = {mem_req, mem_we, ir_we, reg_we,
                    pc_we, alu_s};

  initial begin
    reset     = 1'b1;
    mem_rdata = 32'd0;
    mem_ready = 1'b0;
    cmp       = 1'b0;
    tick();
    tick();
    chk("rst_strobes", 32'(strobes), 32'd0);
    chk("rst_imm", imm, 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_wb_sel", 32'(wb_sel), 32'd0);
    reset = 1'b0;
    #1;
    chk("start_req", 32'(mem_req), 32'd0);
    tick();
    chk("fetch_req", 32'(mem_req), 32'd1);
    chk("fetch_wait_ir_we", 32'(ir_we), 32'd0);
    tick();
    chk("fetch_hold_req", 32'(mem_req), 32'd1);

    // ADD x3,x1,x2
    fetch(32'h002081B3);
    chk("add_dec_req", 32'(mem_req), 32'd0);
    tick();
    chk("add_alu_s", 32'(alu_s), 32'b000001);
    chk("add_b_sel", 32'(alu_b_sel), 32'd0);
    chk("add_a_sel", 32'(alu_a_sel), 32'd0);
    chk("add_rs1", 32'(rs1_addr), 32'd1);
    chk("add_rs2", 32'(rs2_addr), 32'd2);
    tick();
    chk("add_reg_we", 32'(reg_we), 32'd1);
    chk("add_pc_we", 32'(pc_we), 32'd1);
    chk("add_rd", 32'(rd_addr), 32'd3);
    chk("add_wb_sel", 32'(wb_sel), 32'd0);
    chk("add_pc_sel", 32'(pc_sel), 32'd0);
    chk("add_wb_alu_s", 32'(alu_s), 32'd0);
    tick();

    // SRAI x5,x6,3 with a stray READY during DECODE
    fetch(32'h40335293);
    mem_rdata = 32'hFFFFFFFF;
    mem_ready = 1'b1;
    #1;
    chk("srai_dec_ir_we", 32'(ir_we), 32'd0);
    tick();
    mem_ready = 1'b0;
    chk("srai_alu_s", 32'(alu_s), 32'b110101);
    chk("srai_imm", imm, 32'h00000003);
    chk("srai_b_sel", 32'(alu_b_sel), 32'd1);
    chk("srai_rd", 32'(rd_addr), 32'd5);
    tick();
    chk("srai_reg_we", 32'(reg_we), 32'd1);
    tick();

    // BNE x1,x2,+8
    fetch(32'h00209463);
    tick();
    chk("bne_alu_s", 32'(alu_s), 32'b000110);
    chk("bne_imm", imm, 32'd8);
    chk("bne_b_sel", 32'(alu_b_sel), 32'd0);
    cmp = 1'b1;
    #1;
    chk("bne_t_pc_we", 32'(pc_we), 32'd1);
    chk("bne_t_pc_sel", 32'(pc_sel), 32'b01);
    chk("bne_t_reg_we", 32'(reg_we), 32'd0);
    cmp = 1'b0;
    #1;
    chk("bne_n_pc_we", 32'(pc_we), 32'd1);
    chk("bne_n_pc_sel", 32'(pc_sel), 32'b00);
    chk("bne_n_reg_we", 32'(reg_we), 32'd0);
    tick();
    chk("bne_next_fetch", 32'(mem_req), 32'd1);
    chk("bne_next_reg_we", 32'(reg_we), 32'd0);

    // LW x4,16(x2), READY three cycles late
    fetch(32'h01012203);
    tick();
    chk("lw_alu_s", 32'(alu_s), 32'b000001);
    chk("lw_imm", imm, 32'd16);
    chk("lw_b_sel", 32'(alu_b_sel), 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("lw_mem_req", 32'(mem_req), 32'd1);
      chk("lw_mem_we", 32'(mem_we), 32'd0);
      chk("lw_mem_reg_we", 32'(reg_we), 32'd0);
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    mem_ready = 1'b0;
    chk("lw_reg_we", 32'(reg_we), 32'd1);
    chk("lw_wb_sel", 32'(wb_sel), 32'b01);
    chk("lw_rd", 32'(rd_addr), 32'd4);
    chk("lw_funct3", 32'(funct3), 32'b010);
    tick();

    // SW x2,4(x1), reset while MEM is waiting
    fetch(32'h0020A223);
    tick();
    chk("sw_imm", imm, 32'd4);
    tick();
    chk("sw_mem_req", 32'(mem_req), 32'd1);
    chk("sw_mem_we", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    chk("sw_rst_req", 32'(mem_req), 32'd0);
    chk("sw_rst_we", 32'(mem_we), 32'd0);
    chk("sw_rst_reg_we", 32'(reg_we), 32'd0);
    tick();
    chk("sw_rst_hold", 32'(strobes), 32'd0);
    reset = 1'b0;
    #1;
    chk("sw_start_req", 32'(mem_req), 32'd0);
    tick();
    chk("sw_fetch_req", 32'(mem_req), 32'd1);

    // SW completing normally
    fetch(32'h0020A223);
    tick();
    tick();
    chk("sw2_mem_we", 32'(mem_we), 32'd1);
    chk("sw2_wait_pc_we", 32'(pc_we), 32'd0);
    mem_ready = 1'b1;
    #1;
    chk("sw2_pc_we", 32'(pc_we), 32'd1);
    chk("sw2_pc_sel", 32'(pc_sel), 32'b00);
    tick();
    mem_ready = 1'b0;
    chk("sw2_next_fetch", 32'(mem_req), 32'd1);
    chk("sw2_reg_we", 32'(reg_we), 32'd0);

    // Illegal word
    fetch(32'hFFFFFFFF);
    chk("ill_dec_flag", 32'(illegal), 32'd0);
    tick();
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      cmp       = i[1];
      #1;
      chk("trap_strobes", 32'(strobes), 32'd0);
      chk("trap_illegal", 32'(illegal), 32'd1);
      tick();
    end
    mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("ill_cleared", 32'(illegal), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_trap_fetch", 32'(mem_req), 32'd1);

    $display("%0d/%0d checks passed", passes, passes + fails);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_fsm.md
Name: alu_ctrl_fsm

Overview:
- Multicycle RV32I control unit. It is the producer side of the 6-bit ALU operation-select bus: it drives S, and consumes the ALU's CMP result.
- It fetches an instruction over a single ready/request memory port and latches it into an internal IR.
- It decodes the IR into the ALU select code, register addresses, immediate and datapath strobes, then sequences the per-instruction states.
- Sits between the memory interface and the datapath (register file, PC, ALU).

Parameters:
- RESET_TRAP, 0, when 1, ILLEGAL also forces HALT of PC_WE (always 0 in TRAP regardless); kept for bench visibility only.

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- MEM_RDATA  in  32  memory read data; instruction word during FETCH
- MEM_READY  in  1  memory completes the current request this cycle
- CMP  in  1  ALU compare result
- MEM_REQ  out  1  memory request, held until MEM_READY
- MEM_WE  out  1  store request (valid with MEM_REQ)
- IR_WE  out  1  IR capture pulse (also the internal IR load)
- ALU_S  out  6  ALU operation select
- ALU_A_SEL  out  1  0 = rs1, 1 = PC
- ALU_B_SEL  out  1  0 = rs2, 1 = IMM
- RS1_ADDR, RS2_ADDR, RD_ADDR  out  5 each  fields of the IR
- FUNCT3  out  3  IR[14:12], for load/store sizing
- IMM  out  32  decoded immediate
- REG_WE  out  1  register-file write
- WB_SEL  out  2  00 ALU Q, 01 MEM_RDATA, 10 PC+4, 11 IMM
- PC_WE  out  1  PC update
- PC_SEL  out  2  00 PC+4, 01 PC+IMM, 10 ALU Q & ~1
- ILLEGAL  out  1  sticky illegal-instruction flag

Behaviour:
- States: START, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset:
  - RESET → START asynchronously; IR = 0; ILLEGAL = 0.
  - All strobes 0; ALU_S = 000000; IMM = 0.
- START: no strobes; next state FETCH.
- FETCH:
  - MEM_REQ = 1.
  - On MEM_READY: IR_WE = 1, IR ← MEM_RDATA, go to DECODE; otherwise stay.
- DECODE:
  - Go to TRAP on an unsupported opcode/funct; ILLEGAL ← 1.
  - Otherwise go to EXEC. Supported set: RV32I minus FENCE/SYSTEM.
- EXEC:
  - ALU_S is per the table below; A/B selects are per instruction class.
  - Branch: PC_WE = 1; PC_SEL = CMP ? 01 : 00; next FETCH.
  - Load/store: ALU_S = ADD; next MEM.
  - All others: next WB.
- MEM:
  - MEM_REQ = 1; MEM_WE = 1 for stores. Hold until MEM_READY.
  - On READY, a load goes to WB. A store goes to FETCH with PC_WE = 1 and PC_SEL = 00.
- WB:
  - REG_WE = 1 and PC_WE = 1.
  - PC_SEL = 01 for JAL, 10 for JALR, else 00.
  - WB_SEL = 10 for JAL/JALR, 11 for LUI, 01 for loads, else 00.
  - Next state FETCH.
- TRAP: terminal; all strobes 0; leave only via RESET.
- ALU_S encoding is {b5, funct3, is_br, is_arith}:
  - ADD 000001, SUB 100001, SLL 000101, SLT 001001, SLTU 001101, XOR 010001, SRL 010101, SRA 110101, OR 011001, AND 011101.
  - EQ 000010, NE 000110, LT 010010, GE 010110, LTU 011010, GEU 011110.
  - R-type: b5 = IR[30].
  - I-arith: b5 = IR[30] only when funct3 = 101, else 0. SUB is never produced from I-type.
  - Branch: b5 = 0.
  - Load/store/AUIPC/JAL/JALR: ADD.
- ALU_S is driven only in EXEC. It is 000000 in all other states.
- IMM formats (sign-extended): I, S, B, U, J.
  - Shifts: IMM = {27'b0, IR[24:20]}, because the ALU shifts by the full B operand.
- Operand selects:
  - AUIPC: A = PC, B = IMM.
  - JAL: A = PC, B = IMM.
  - JALR: A = rs1, B = IMM.
- Latency, in cycles excluding memory wait: R/I/LUI/AUIPC/JAL/JALR 4; branch 3; store 4; load 5.
- PC_SEL in EXEC is combinational on CMP. All other outputs are decoded from state and IR.
- Boundary conditions:
  - MEM_READY outside FETCH/MEM is ignored.
  - MEM_READY low indefinitely: stay in the current state with MEM_REQ held.
  - RESET mid-MEM: MEM_REQ and MEM_WE drop asynchronously and no REG_WE is issued.

Decomposition:
- Shared package holds:
  - the ALU_S codes, the same constants the ALU uses;
  - the opcode constants;
  - the state enum;
  - the WB_SEL and PC_SEL encodings.
- One sub-module, alu_ctrl_imm_gen: combinational IR → IMM.

Test Plan:
1. RESET, then FETCH returns 0x002081B3 (ADD x3,x1,x2) → EXEC ALU_S = 000001, B_SEL = 0; WB REG_WE = 1, RD_ADDR = 3, WB_SEL = 00, PC_SEL = 00.
2. 0x40335293 (SRAI x5,x6,3) → ALU_S = 110101, IMM = 0x00000003, B_SEL = 1, RD_ADDR = 5.
3. 0x00209463 (BNE x1,x2,+8) → ALU_S = 000110, IMM = 8.
   - CMP = 1 → PC_WE = 1, PC_SEL = 01.
   - CMP = 0 → PC_SEL = 00.
   - No REG_WE in either case; next state FETCH.
4. 0x01012203 (LW x4,16(x2)) with MEM_READY delayed 3 cycles in MEM → MEM_REQ = 1 and MEM_WE = 0 for 4 cycles; then WB with WB_SEL = 01, RD_ADDR = 4.
5. 0xFFFFFFFF fetched → ILLEGAL = 1, TRAP. Zero strobes for 20 cycles; ILLEGAL clears only on RESET.
6. RESET asserted in MEM of a store → MEM_REQ/MEM_WE drop the same cycle; after release, START then FETCH with MEM_REQ = 1.
